// File: rtl/ov7670_pkg.sv
// Shared constants, state encodings and default register table for the OV7670 SCCB configurator.
package ov7670_pkg;

    localparam logic [7:0] SCCB_ID_WRITE = 8'h42;
    localparam logic [7:0] REG_COM7      = 8'h12;
    localparam logic [7:0] COM7_RESET    = 8'h80;

    localparam int unsigned MAX_REGS = 256;
    localparam int unsigned ENTRY_W  = 16;

    // Table entry layout: {addr[15:8], value[7:0]}
    typedef logic [MAX_REGS-1:0][ENTRY_W-1:0] cfg_table_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_BIT   = 4'd2,
        ST_XBIT  = 4'd3,
        ST_STOP  = 4'd4,
        ST_GAP   = 4'd5,
        ST_WAIT  = 4'd6,
        ST_NEXT  = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // Default RGB565 / QCIF bring-up sequence; entry 0 is always the soft reset.
    function automatic cfg_table_t default_table();
        cfg_table_t t;
        t      = '0;
        t[0]   = {REG_COM7, COM7_RESET};
        t[1]   = 16'h120C;
        t[2]   = 16'h1101;
        t[3]   = 16'h0C0C;
        t[4]   = 16'h3E11;
        t[5]   = 16'h40D0;
        t[6]   = 16'h3A04;
        t[7]   = 16'h3DC0;
        t[8]   = 16'h7011;
        t[9]   = 16'h7135;
        t[10]  = 16'h7211;
        t[11]  = 16'h73F1;
        t[12]  = 16'hA202;
        t[13]  = 16'h1500;
        t[14]  = 16'h8C00;
        t[15]  = 16'h1E00;
        return t;
    endfunction

    localparam cfg_table_t DEFAULT_TABLE = default_table();

    // A COM7 write with bit 7 set resets the sensor and needs a settle time afterwards.
    function automatic logic is_soft_reset(input logic [ENTRY_W-1:0] entry);
        return (entry[15:8] == REG_COM7) && entry[7];
    endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// Combinational register-table lookup; swap TABLE to change resolution/format.
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter cfg_table_t TABLE = DEFAULT_TABLE
)(
    input  logic [7:0]  i_idx,
    output logic [15:0] o_entry_c
);

    assign o_entry_c = TABLE[i_idx];

endmodule

// File: rtl/sccb_config_ov7670.sv
// Write-only SCCB master that streams the OV7670 register table after a start pulse.
module sccb_config_ov7670
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned SCCB_FREQ  = 100000,
    parameter int unsigned N_REGS     = 16,
    parameter int unsigned GAP_QT     = 4,
    parameter int unsigned RESET_WAIT = 50000,
    parameter cfg_table_t  TABLE      = DEFAULT_TABLE
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic       SDIOC,
    output logic       SDIOD,
    output logic       ocupado,
    output logic       pronto,
    output logic [7:0] idx,
    output logic [3:0] db_estado
);

    localparam int unsigned DIV    = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned QCNT_W = 16;
    localparam int unsigned WAIT_W = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;

    state_t              r_state;
    logic                r_sdioc;
    logic                r_sdiod;
    logic                r_ocupado;
    logic                r_pronto;
    logic [7:0]          r_idx;
    logic [7:0]          r_shreg;
    logic [3:0]          r_bitcnt;
    logic [1:0]          r_ph;
    logic [1:0]          r_byte;
    logic [QCNT_W-1:0]   r_qcnt;
    logic [WAIT_W-1:0]   r_wcnt;
    logic [DIV_W-1:0]    r_div;
    logic                w_qt;
    logic [15:0]         w_entry;

    ov7670_config_rom #(
        .TABLE (TABLE)
    ) u_rom (
        .i_idx     (r_idx),
        .o_entry_c (w_entry)
    );

    assign w_qt      = r_ocupado && (r_div == DIV_W'(DIV - 1));
    assign SDIOC     = r_sdioc;
    assign SDIOD     = r_sdiod;
    assign ocupado   = r_ocupado;
    assign pronto    = r_pronto;
    assign idx       = r_idx;
    assign db_estado = r_state;

    // Quarter-bit divider, held at zero whenever no sequence is running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (!r_ocupado || w_qt) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Sequencer: START, 3 x (8 data bits + released 9th bit), STOP, gap, optional reset settle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sdioc   <= 1'b1;
            r_sdiod   <= 1'b1;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_idx     <= '0;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_ph      <= '0;
            r_byte    <= '0;
            r_qcnt    <= '0;
            r_wcnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iniciar) begin
                        r_ocupado <= 1'b1;
                        r_pronto  <= 1'b0;
                        r_idx     <= '0;
                        r_shreg   <= SCCB_ID_WRITE;
                        r_byte    <= '0;
                        r_qcnt    <= '0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_qt) begin
                        if (r_qcnt == QCNT_W'(0)) begin
                            r_sdiod <= 1'b0;
                            r_qcnt  <= QCNT_W'(1);
                        end else begin
                            r_sdioc  <= 1'b0;
                            r_bitcnt <= 4'd8;
                            r_ph     <= '0;
                            r_state  <= ST_BIT;
                        end
                    end
                end
                ST_BIT, ST_XBIT: begin
                    if (w_qt) begin
                        r_ph <= r_ph + 2'd1;
                        case (r_ph)
                            2'd0: r_sdiod <= (r_state == ST_BIT) ? r_shreg[7] : 1'b1;
                            2'd2: r_sdioc <= 1'b1;
                            2'd3: begin
                                r_sdioc <= 1'b0;
                                if (r_state == ST_BIT) begin
                                    r_shreg  <= {r_shreg[6:0], 1'b0};
                                    r_bitcnt <= r_bitcnt - 4'd1;
                                    if (r_bitcnt == 4'd1) begin
                                        r_state <= ST_XBIT;
                                    end
                                end else begin
                                    case (r_byte)
                                        2'd0: begin
                                            r_shreg  <= w_entry[15:8];
                                            r_byte   <= 2'd1;
                                            r_bitcnt <= 4'd8;
                                            r_state  <= ST_BIT;
                                        end
                                        2'd1: begin
                                            r_shreg  <= w_entry[7:0];
                                            r_byte   <= 2'd2;
                                            r_bitcnt <= 4'd8;
                                            r_state  <= ST_BIT;
                                        end
                                        default: begin
                                            r_qcnt  <= '0;
                                            r_state <= ST_STOP;
                                        end
                                    endcase
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STOP: begin
                    if (w_qt) begin
                        if (r_qcnt == QCNT_W'(0)) begin
                            r_sdiod <= 1'b0;
                            r_qcnt  <= QCNT_W'(1);
                        end else if (r_qcnt == QCNT_W'(1)) begin
                            r_sdioc <= 1'b1;
                            r_qcnt  <= QCNT_W'(2);
                        end else begin
                            r_sdiod <= 1'b1;
                            r_qcnt  <= '0;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_qt) begin
                        if (r_qcnt == QCNT_W'(GAP_QT - 1)) begin
                            r_qcnt <= '0;
                            r_wcnt <= '0;
                            r_state <= is_soft_reset(w_entry) ? ST_WAIT : ST_NEXT;
                        end else begin
                            r_qcnt <= r_qcnt + QCNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if ((RESET_WAIT == 0) || (r_wcnt == WAIT_W'(RESET_WAIT - 1))) begin
                        r_state <= ST_NEXT;
                    end else begin
                        r_wcnt <= r_wcnt + WAIT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (r_idx == 8'(N_REGS - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_shreg <= SCCB_ID_WRITE;
                        r_byte  <= '0;
                        r_qcnt  <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_DONE: begin
                    r_ocupado <= 1'b0;
                    r_pronto  <= 1'b1;
                    r_sdioc   <= 1'b1;
                    r_sdiod   <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_config_ov7670.sv
// Scoreboard bench: stimulus queues expected SCCB frames, a bus decoder pops and compares them.
`timescale 1ns/1ps
module tb_sccb_config_ov7670;
    import ov7670_pkg::*;

    localparam int unsigned N    = 16;
    localparam int unsigned GAPQ = 4;
    localparam int unsigned RW   = 20;

    // Bench table: mixes soft-reset entries with near-miss COM7 / bit7 values.
    function automatic cfg_table_t tb_table();
        cfg_table_t t;
        t     = '0;
        t[0]  = 16'h1280;  t[1]  = 16'h1101;  t[2]  = 16'h3A04;  t[3]  = 16'h1214;
        t[4]  = 16'h9280;  t[5]  = 16'h40D0;  t[6]  = 16'h12FF;  t[7]  = 16'h0C0C;
        t[8]  = 16'h1200;  t[9]  = 16'h3E11;  t[10] = 16'h7011;  t[11] = 16'h1380;
        t[12] = 16'hA202;  t[13] = 16'h1500;  t[14] = 16'h8C00;  t[15] = 16'h1E01;
        return t;
    endfunction
    localparam cfg_table_t TB_TABLE = tb_table();

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       SDIOC, SDIOD, ocupado, pronto;
    logic [7:0] idx;
    logic [3:0] db_estado;

    sccb_config_ov7670 #(
        .CLK_FREQ   (400000),
        .SCCB_FREQ  (100000),
        .N_REGS     (N),
        .GAP_QT     (GAPQ),
        .RESET_WAIT (RW),
        .TABLE      (TB_TABLE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .SDIOC     (SDIOC),
        .SDIOD     (SDIOD),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .idx       (idx),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: observed 0x%0h where none was expected", name, act);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  idx;
        logic [27:0] bits;
        int          gap;
    } exp_t;

    exp_t   q[$];
    longint exp_pronto_cyc;
    bit     exp_pronto_valid = 0;
    longint exp_first_cyc;
    bit     first_pending = 0;
    logic   model_pronto = 1'b0;

    function automatic bit soft_rst(input logic [15:0] e);
        return (e[15:8] == 8'h12) && (e[7] == 1'b1);
    endfunction

    // Cycles from the accepting edge to pronto: per entry 113 bus quarters, the gap,
    // one NEXT cycle and any settle wait, then one DONE cycle.
    function automatic longint run_cycles();
        longint t = 1;
        for (int i = 0; i < int'(N); i++)
            t += 113 + GAPQ + 1 + (soft_rst(TB_TABLE[i]) ? RW : 0);
        return t;
    endfunction

    // ---------------- bus monitor / scoreboard ----------------
    logic        pc = 1'b1, pd = 1'b1, pp = 1'b0;
    bit          in_frame = 0;
    int          nbits = 0;
    logic [27:0] sh;
    int          idle_cnt = 0;
    bit          gap_pending = 0;
    int          exp_gap = 0;
    int          starts_seen = 0;
    exp_t        mon_e;

    // Bits are captured on every SDIOC rise; the rise that sets up STOP captures a trailing 0.
    always @(negedge clock) begin
        if (!reset) begin
            in_frame = 0; gap_pending = 0; idle_cnt = 0;
            pc = 1'b1; pd = 1'b1; pp = 1'b0;
        end else begin
            if (pc && SDIOC && pd && !SDIOD) begin
                starts_seen++;
                if (in_frame) fail_evt("start_inside_frame", 64'(nbits));
                if (q.size() == 0) begin
                    fail_evt("unexpected_start", 64'(idx));
                end else begin
                    chk("idx_at_start", 64'(idx), 64'(q[0].idx));
                    if (gap_pending) chk("idle_gap_cycles", 64'(idle_cnt), 64'(exp_gap));
                end
                if (first_pending) begin
                    chk("first_start_cycle", 64'(cyc), 64'(exp_first_cyc));
                    first_pending = 0;
                end
                chk("ocupado_during_frame", 64'(ocupado), 64'd1);
                gap_pending = 0; in_frame = 1; nbits = 0; sh = '0;
            end else if (pc && SDIOC && !pd && SDIOD) begin
                if (!in_frame || q.size() == 0) begin
                    fail_evt("unexpected_stop", 64'(nbits));
                end else begin
                    mon_e = q.pop_front();
                    chk("frame_bit_count", 64'(nbits), 64'd28);
                    chk("frame_bits", 64'(sh), 64'(mon_e.bits));
                    exp_gap = mon_e.gap;
                    gap_pending = 1;
                end
                in_frame = 0; idle_cnt = 1;
            end else if (pc && SDIOC && (pd != SDIOD)) begin
                fail_evt("sdiod_edge_with_sdioc_high", 64'(SDIOD));
            end else if (!pc && SDIOC && in_frame) begin
                sh = {sh[26:0], SDIOD};
                nbits++;
            end else if (!in_frame && SDIOC && SDIOD) begin
                idle_cnt++;
            end

            if (!pp && pronto) begin
                if (!exp_pronto_valid) begin
                    fail_evt("pronto_unexpected_rise", 64'(cyc));
                end else begin
                    chk("pronto_rise_cycle", 64'(cyc), 64'(exp_pronto_cyc));
                    chk("all_frames_seen", 64'(q.size()), 64'd0);
                    exp_pronto_valid = 0;
                end
                gap_pending = 0;
            end
            pc = SDIOC; pd = SDIOD; pp = pronto;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_run(output int base);
        exp_t e;
        @(negedge clock);
        chk("pronto_before_start", 64'(pronto), 64'(model_pronto));
        base = starts_seen;
        iniciar = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            e.idx  = 8'(i);
            e.bits = {8'h42, 1'b1, TB_TABLE[i][15:8], 1'b1, TB_TABLE[i][7:0], 1'b1, 1'b0};
            e.gap  = GAPQ + 2 + (soft_rst(TB_TABLE[i]) ? RW : 0);
            q.push_back(e);
        end
        exp_first_cyc    = cyc + 2;
        first_pending    = 1;
        exp_pronto_cyc   = cyc + 1 + run_cycles();
        exp_pronto_valid = 1;
        @(negedge clock);
        iniciar = 1'b0;
        model_pronto = 1'b0;
        chk("pronto_cleared_on_accept", 64'(pronto), 64'd0);
        chk("ocupado_on_accept", 64'(ocupado), 64'd1);
        chk("idx_on_accept", 64'(idx), 64'd0);
    endtask

    task automatic pulse_iniciar();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_done();
        longint budget = run_cycles() + 100;
        longint n = 0;
        while (!pronto && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!pronto) begin
            fail_evt("timeout_waiting_pronto", 64'(n));
        end else begin
            chk("ocupado_after_done", 64'(ocupado), 64'd0);
            chk("state_idle_after_done", 64'(db_estado), 64'd0);
            model_pronto = 1'b1;
        end
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (starts_seen < target && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (starts_seen < target) fail_evt("timeout_waiting_start", 64'(starts_seen));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_sdioc"}, 64'(SDIOC), 64'd1);
        chk({tag, "_sdiod"}, 64'(SDIOD), 64'd1);
        chk({tag, "_ocupado"}, 64'(ocupado), 64'd0);
        chk({tag, "_state"}, 64'(db_estado), 64'd0);
    endtask

    initial begin
        int base;
        int k;
        int n;
        reset   = 1'b0;
        iniciar = 1'b0;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        chk("reset_pronto", 64'(pronto), 64'd0);
        chk("reset_idx", 64'(idx), 64'd0);
        reset = 1'b1;

        repeat (1000) @(negedge clock);
        check_quiet("idle");
        chk("idle_pronto", 64'(pronto), 64'd0);

        // Plain run after a random delay.
        repeat ($urandom_range(1, 20)) @(negedge clock);
        start_run(base);
        wait_done();

        // Start pulse while entry 5 is on the bus.
        repeat ($urandom_range(1, 20)) @(negedge clock);
        start_run(base);
        wait_starts(base + 6);
        repeat ($urandom_range(1, 100)) @(negedge clock);
        pulse_iniciar();
        wait_done();

        // Several random start pulses while busy.
        start_run(base);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(10, 400)) @(negedge clock);
            pulse_iniciar();
        end
        wait_done();

        // Asynchronous reset during the address byte of entry 3.
        start_run(base);
        k = $urandom_range(9, 16);
        wait_starts(base + 4);
        n = 0;
        while (nbits != k && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (nbits != k) fail_evt("timeout_waiting_addr_byte", 64'(nbits));
        #2;
        reset = 1'b0;
        #1;
        check_quiet("midrun_reset");
        chk("midrun_reset_idx", 64'(idx), 64'd0);
        chk("midrun_reset_pronto", 64'(pronto), 64'd0);
        q.delete();
        exp_pronto_valid = 0;
        first_pending    = 0;
        model_pronto     = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check_quiet("after_reset");

        // Fresh run must restart from entry 0.
        start_run(base);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sccb_config_ov7670.md
Name: sccb_config_ov7670

Overview:
- SCCB (I2C-like) write-only master that configures the OV7670 after power-up, before frame capture starts.
- On a start pulse it walks an internal register table and emits one 3-phase write per entry on SDIOC/SDIOD: camera ID 0x42, register address, value.
- It drives the SDIOC/SDIOD pins of the camera interface top level. Its `pronto` output gates the capture `iniciar` path.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- SCCB_FREQ, 100000: SCCB bit rate in Hz. Quarter-bit divisor DIV = CLK_FREQ/(4*SCCB_FREQ), 125 at the defaults.
- N_REGS, 16: number of {address,value} entries in the table, 1..256.
- GAP_QT, 4: idle quarter-ticks between consecutive transactions.
- RESET_WAIT, 50000: clock cycles to wait after writing register 0x12 with bit 7 set (soft reset, 1 ms at 50 MHz).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  one-cycle start pulse (edge-detected upstream).
- SDIOC  out  1  SCCB clock.
- SDIOD  out  1  SCCB data; 1 = released/high, 0 = driven low.
- ocupado  out  1  high while a table sequence is running.
- pronto  out  1  high after the whole table has been written; held until the next accepted `iniciar`.
- idx  out  8  index of the entry currently being written, for debug.
- db_estado  out  4  current FSM state encoding.

Behaviour:
- Reset (reset=0, asynchronous): SDIOC=1, SDIOD=1, ocupado=0, pronto=0, idx=0, db_estado=0 (IDLE), divider=0.
- Quarter tick: a divider counts 0..DIV-1 and asserts `qt` for one cycle at DIV-1. The divider runs only while ocupado=1 and is cleared in IDLE. Every line change below happens on a `qt` cycle.
- IDLE (0): on `iniciar`=1, set ocupado=1, clear pronto, set idx=0, load the shift register with 0x42, go to START.
  - `iniciar` is ignored in every other state.
- START (1), 2 quarter-ticks:
  - qt1: SDIOD goes 0 while SDIOC=1.
  - qt2: SDIOC goes 0.
  - Then go to BIT with bit counter 8 and phase 0.
- BIT (2), 4 quarter-ticks per bit, MSB first:
  - ph0: SDIOD = shreg[7].
  - ph1: hold.
  - ph2: SDIOC goes 1.
  - ph3: hold. On the next qt, SDIOC goes 0 and the register shifts left.
  - After 8 bits go to XBIT.
- XBIT (3): the 9th "don't care" bit, timed exactly like BIT with SDIOD=1 (released). The ACK is not sampled.
  - After phase 1 (ID byte): load the address.
  - After phase 2 (address byte): load the value.
  - After phase 3 (value byte): go to STOP.
- STOP (4), 3 quarter-ticks:
  - qt1: SDIOD=0 with SDIOC=0.
  - qt2: SDIOC goes 1.
  - qt3: SDIOD goes 1.
- GAP (5): wait GAP_QT quarter-ticks with SDIOC=SDIOD=1.
  - If the entry just written had address 0x12 and value[7]=1, go to WAIT.
  - Otherwise go to NEXT.
- WAIT (6): count RESET_WAIT clock cycles, then go to NEXT.
- NEXT (7):
  - If idx==N_REGS-1: go to DONE.
  - Else: idx+1, load 0x42, go to START.
- DONE (8): ocupado=0, pronto=1, both lines 1, return to IDLE on the same cycle. pronto stays high.
- Bus invariant: SDIOD changes only while SDIOC=0, except the START fall and the STOP rise, which occur with SDIOC=1.
- Transaction length: 2 + 27*4 + 3 = 113 quarter-ticks, plus GAP_QT.
- Reset mid-transfer: lines return to 1 immediately (asynchronous). No STOP is emitted. The camera resyncs on the next START.
- Table entry format: 16 bits, {addr[15:8], value[7:0]}.
  - Entry 0 is {0x12,0x80}.
  - Remaining defaults are the RGB565/QCIF set; the values are owned by the package.

Decomposition:
- Shared package `ov7670_pkg`:
  - SCCB_ID_WRITE = 8'h42, REG_COM7 = 8'h12, COM7_RESET = 8'h80.
  - The default configuration table as a constant array.
  - The state encodings.
- Sub-module `ov7670_config_rom`: combinational lookup, idx(8) -> entry(16). Replaceable per resolution.
- Top-level FSM, divider and shift register live in `sccb_config_ov7670`.

Test Plan:
- Idle check: reset released, no `iniciar` for 1000 cycles -> SDIOC=SDIOD=1, ocupado=0, pronto=0, db_estado=0.
- Single write (CLK_FREQ=400000, SCCB_FREQ=100000 so DIV=1, N_REGS=1, table {0x3A,0x04}, RESET_WAIT=0):
  - Pulse `iniciar`; the bench decodes the bus -> START, bytes 0x42, 0x3A, 0x04 each followed by an X bit with SDIOD=1, then STOP.
  - pronto=1 exactly 113+GAP_QT+NEXT/DONE overhead cycles after `iniciar`.
- Soft-reset wait (table {0x12,0x80},{0x11,0x01}, RESET_WAIT=20) -> at least 20 idle cycles with both lines high between the first STOP and the second START; second transaction is 0x42, 0x11, 0x01.
- Bus protocol monitor over a full 16-entry run:
  - No SDIOD edge while SDIOC=1 except START/STOP.
  - Exactly 16 STARTs; idx steps 0..15.
  - pronto rises once.
- Start pulse ignored while busy: `iniciar` pulsed during entry 5 -> sequence unaffected, still 16 transactions.
- Reset mid-operation:
  - reset=0 during the address byte of entry 3 -> SDIOC=SDIOD=1 within the same cycle, ocupado=0.
  - After release plus a new `iniciar`, the run restarts at idx=0.
